// File: rtl/fft_pkg.sv
// Shared constants and FSM state encodings for the 8-point FFT frame sequencer.
package fft_pkg;
    localparam int N_DEF        = 3;
    localparam int W            = 2 ** N_DEF;
    localparam int FRAME        = 8;
    localparam int IDX_W        = 3;
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [0:0] {
        IN_FILL = 1'b0,
        IN_FULL = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_WAIT  = 2'd1,
        OUT_DRAIN = 2'd2
    } out_state_t;
endpackage

// File: rtl/fft_frame_buf.sv
// Eight-slot complex register file: single indexed write or whole-frame load, flattened parallel read.
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int W = fft_pkg::W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [W-1:0]       wre,
    input  logic [W-1:0]       wim,
    input  logic               ld,
    input  logic [FRAME*W-1:0] ld_re,
    input  logic [FRAME*W-1:0] ld_im,
    output logic [FRAME*W-1:0] rd_re,
    output logic [FRAME*W-1:0] rd_im
);
    logic [FRAME*W-1:0] re_r;
    logic [FRAME*W-1:0] im_r;

    // Slot storage; a whole-frame load takes priority over a single-slot write.
    always_ff @(posedge clk) begin
        if (rst) begin
            re_r <= '0;
            im_r <= '0;
        end else if (ld) begin
            re_r <= ld_re;
            im_r <= ld_im;
        end else if (we) begin
            re_r[waddr*W +: W] <= wre;
            im_r[waddr*W +: W] <= wim;
        end
    end

    assign rd_re = re_r;
    assign rd_im = im_r;
endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: collects 8 samples, launches them into the FFT core under a single-frame credit,
// captures the results after the core latency and streams them out with valid/ready.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [(2**N)-1:0]         s_re,
    input  logic [(2**N)-1:0]         s_im,
    output logic [FRAME*(2**N)-1:0]   core_in_re,
    output logic [FRAME*(2**N)-1:0]   core_in_im,
    output logic                      core_start,
    input  logic [FRAME*(2**N)-1:0]   core_out_re,
    input  logic [FRAME*(2**N)-1:0]   core_out_im,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [(2**N)-1:0]         m_re,
    output logic [(2**N)-1:0]         m_im,
    output logic [IDX_W-1:0]          m_index,
    output logic                      m_last,
    output logic                      busy
);
    localparam int WD    = 2 ** N;
    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    in_state_t          in_state_r, in_next_s;
    out_state_t         out_state_r, out_next_s;
    logic [IDX_W-1:0]   cnt_r, idx_r;
    logic [LAT_W-1:0]   lat_r;
    logic               credit_r, credit_next_s;
    logic [FRAME*WD-1:0] launch_re_r, launch_im_r;
    logic [FRAME*WD-1:0] slot_re_s, slot_im_s, frame_re_s, frame_im_s;
    logic [FRAME*WD-1:0] obuf_re_s, obuf_im_s;
    logic               s_ready_s, accept_s, launch_s, release_s, capture_s, load_launch_s;

    assign s_ready_s = (in_state_r == IN_FILL) && !rst;
    assign accept_s  = s_valid && s_ready_s;
    assign launch_s  = (in_state_r == IN_FULL) && credit_r;
    assign release_s = (out_state_r == OUT_DRAIN) && m_ready && (idx_r == 3'd7);
    assign capture_s = (out_state_r == OUT_WAIT) && (lat_r == '0);

    fft_frame_buf #(.W(WD)) u_in_buf (
        .clk(clk), .rst(rst), .we(accept_s), .waddr(cnt_r), .wre(s_re), .wim(s_im),
        .ld(1'b0), .ld_re('0), .ld_im('0), .rd_re(slot_re_s), .rd_im(slot_im_s)
    );

    fft_frame_buf #(.W(WD)) u_out_buf (
        .clk(clk), .rst(rst), .we(1'b0), .waddr('0), .wre('0), .wim('0),
        .ld(capture_s), .ld_re(core_out_re), .ld_im(core_out_im),
        .rd_re(obuf_re_s), .rd_im(obuf_im_s)
    );

    // Input FSM next state.
    always_comb begin
        in_next_s = in_state_r;
        case (in_state_r)
            IN_FILL: if (accept_s && (cnt_r == 3'd7)) in_next_s = IN_FULL; else in_next_s = IN_FILL;
            IN_FULL: if (launch_s) in_next_s = IN_FILL; else in_next_s = IN_FULL;
            default: in_next_s = IN_FILL;
        endcase
    end

    // Output FSM next state.
    always_comb begin
        out_next_s = out_state_r;
        case (out_state_r)
            OUT_IDLE:  if (launch_s) out_next_s = OUT_WAIT; else out_next_s = OUT_IDLE;
            OUT_WAIT:  if (lat_r == '0) out_next_s = OUT_DRAIN; else out_next_s = OUT_WAIT;
            OUT_DRAIN: if (release_s) out_next_s = OUT_IDLE; else out_next_s = OUT_DRAIN;
            default:   out_next_s = OUT_IDLE;
        endcase
    end

    // Credit and launch-register load: the launch register is filled on the edge before core_start,
    // merging the sample being accepted so a frame completing this edge is already complete.
    always_comb begin
        credit_next_s = credit_r;
        if (launch_s) credit_next_s = 1'b0;
        else if (release_s) credit_next_s = 1'b1;
        else credit_next_s = credit_r;
        load_launch_s = (in_next_s == IN_FULL) && credit_next_s;
        frame_re_s = slot_re_s;
        frame_im_s = slot_im_s;
        if (accept_s) begin
            frame_re_s[cnt_r*WD +: WD] = s_re;
            frame_im_s[cnt_r*WD +: WD] = s_im;
        end else begin
            frame_re_s = slot_re_s;
            frame_im_s = slot_im_s;
        end
    end

    // Sequencer state registers; fill and drain indices wrap naturally from 7 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_r  <= IN_FILL;
            out_state_r <= OUT_IDLE;
            cnt_r       <= '0;
            idx_r       <= '0;
            lat_r       <= '0;
            credit_r    <= 1'b1;
            launch_re_r <= '0;
            launch_im_r <= '0;
        end else begin
            in_state_r  <= in_next_s;
            out_state_r <= out_next_s;
            credit_r    <= credit_next_s;
            if (accept_s) cnt_r <= cnt_r + 3'd1;
            if (load_launch_s) begin
                launch_re_r <= frame_re_s;
                launch_im_r <= frame_im_s;
            end
            if (launch_s) lat_r <= LAT_W'(PIPE_LAT - 1);
            else if ((out_state_r == OUT_WAIT) && (lat_r != '0)) lat_r <= lat_r - LAT_W'(1);
            if (capture_s) idx_r <= '0;
            else if ((out_state_r == OUT_DRAIN) && m_ready) idx_r <= idx_r + 3'd1;
        end
    end

    assign s_ready    = s_ready_s;
    assign core_start = launch_s;
    assign core_in_re = launch_re_r;
    assign core_in_im = launch_im_r;
    assign m_valid    = (out_state_r == OUT_DRAIN);
    assign m_index    = idx_r;
    assign m_last     = (out_state_r == OUT_DRAIN) && (idx_r == 3'd7);
    assign m_re       = obuf_re_s[idx_r*WD +: WD];
    assign m_im       = obuf_im_s[idx_r*WD +: WD];
    assign busy       = (cnt_r != '0) || (in_state_r == IN_FULL) || !credit_r;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: directed vector table, corner sequences and random traffic against a queue model.
module tb_fft_frame_ctrl;
    localparam int W  = 8;
    localparam int P  = 3;
    localparam int P5 = 5;

    logic clk = 1'b0;
    logic rst, s_valid, m_ready;
    logic [W-1:0] s_re, s_im;
    logic s_ready, core_start, m_valid, m_last, busy;
    logic [8*W-1:0] core_in_re, core_in_im, core_out_re, core_out_im;
    logic [W-1:0] m_re, m_im;
    logic [2:0] m_index;
    logic s_ready5, core_start5, m_valid5, m_last5, busy5;
    logic [8*W-1:0] core_in_re5, core_in_im5, core_out_re5, core_out_im5;
    logic [W-1:0] m_re5, m_im5;
    logic [2:0] m_index5;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.N(3), .PIPE_LAT(P)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .core_in_re(core_in_re), .core_in_im(core_in_im), .core_start(core_start),
        .core_out_re(core_out_re), .core_out_im(core_out_im), .m_valid(m_valid), .m_ready(m_ready),
        .m_re(m_re), .m_im(m_im), .m_index(m_index), .m_last(m_last), .busy(busy));

    fft_frame_ctrl #(.N(3), .PIPE_LAT(P5)) dut5 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready5), .s_re(s_re), .s_im(s_im),
        .core_in_re(core_in_re5), .core_in_im(core_in_im5), .core_start(core_start5),
        .core_out_re(core_out_re5), .core_out_im(core_out_im5), .m_valid(m_valid5), .m_ready(m_ready),
        .m_re(m_re5), .m_im(m_im5), .m_index(m_index5), .m_last(m_last5), .busy(busy5));

    // Core stand-in: identity for the launched frame, garbage in every other pipeline slot.
    logic [8*W-1:0] c_re[P], c_im[P], c5_re[P5], c5_im[P5];
    always @(posedge clk) begin
        c_re[0]  <= core_start  ? core_in_re  : {$urandom, $urandom};
        c_im[0]  <= core_start  ? core_in_im  : {$urandom, $urandom};
        c5_re[0] <= core_start5 ? core_in_re5 : {$urandom, $urandom};
        c5_im[0] <= core_start5 ? core_in_im5 : {$urandom, $urandom};
        for (int i = 1; i < P; i++) begin
            c_re[i] <= c_re[i-1];
            c_im[i] <= c_im[i-1];
        end
        for (int i = 1; i < P5; i++) begin
            c5_re[i] <= c5_re[i-1];
            c5_im[i] <= c5_im[i-1];
        end
    end
    assign core_out_re  = c_re[P-1];
    assign core_out_im  = c_im[P-1];
    assign core_out_re5 = c5_re[P5-1];
    assign core_out_im5 = c5_im[P5-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: samples awaiting launch, and the one frame in flight with its launch cycle.
    logic [W-1:0] pend_re[$], pend_im[$];
    logic [W-1:0] fl_re[8], fl_im[8];
    bit outstanding = 1'b0;
    int fl_idx = 0;
    int launch_cyc = 0;
    bit e_ready, e_start, e_mvalid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic sample_and_check();
        logic [63:0] exp_re, exp_im;
        @(negedge clk);
        e_ready  = !rst && (pend_re.size() < 8);
        e_start  = !rst && (pend_re.size() == 8) && !outstanding;
        e_mvalid = !rst && outstanding && (cyc >= launch_cyc + P + 1);
        check("s_ready", 64'(s_ready), 64'(e_ready));
        if (!rst) begin
            check("core_start", 64'(core_start), 64'(e_start));
            check("m_valid", 64'(m_valid), 64'(e_mvalid));
            check("busy", 64'(busy), 64'((pend_re.size() != 0) || outstanding));
            if (e_start) begin
                for (int k = 0; k < 8; k++) begin
                    exp_re[k*W +: W] = pend_re[k];
                    exp_im[k*W +: W] = pend_im[k];
                end
                check("core_in_re", core_in_re, exp_re);
                check("core_in_im", core_in_im, exp_im);
            end
            if (e_mvalid) begin
                check("m_re", 64'(m_re), 64'(fl_re[fl_idx]));
                check("m_im", 64'(m_im), 64'(fl_im[fl_idx]));
                check("m_index", 64'(m_index), 64'(fl_idx));
                check("m_last", 64'(m_last), 64'(fl_idx == 7));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            pend_re.delete();
            pend_im.delete();
            outstanding = 1'b0;
            fl_idx = 0;
        end else begin
            if (s_valid && e_ready) begin
                pend_re.push_back(s_re);
                pend_im.push_back(s_im);
            end
            if (e_start) begin
                for (int k = 0; k < 8; k++) begin
                    fl_re[k] = pend_re.pop_front();
                    fl_im[k] = pend_im.pop_front();
                end
                outstanding = 1'b1;
                launch_cyc = cyc;
                fl_idx = 0;
            end
            if (e_mvalid && m_ready) begin
                fl_idx++;
                if (fl_idx == 8) outstanding = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    // vmode: 0 always valid, 1 every 3rd cycle, 2 random, 3 idle. rmode: 0 ready, 1 pattern 1,0,0, 2 random, 3 stalled.
    task automatic drive(input int vmode, input int rmode);
        s_valid = (vmode == 0) || (vmode == 1 && cyc % 3 == 0) || (vmode == 2 && $urandom_range(1) == 1);
        m_ready = (rmode == 0) || (rmode == 1 && cyc % 3 == 0) || (rmode == 2 && $urandom_range(3) != 0);
        s_re = 8'($urandom);
        s_im = 8'($urandom);
    endtask

    task automatic run(input int n, input int vmode, input int rmode);
        for (int i = 0; i < n; i++) begin
            drive(vmode, rmode);
            sample_and_check();
            advance();
        end
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        s_valid = 1'b0;
        sample_and_check();
        advance();
        rst = 1'b0;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_index", 64'(m_index), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_in", {core_in_re ^ core_in_im}, 64'd0);
    endtask

    // Latency probe on the PIPE_LAT=5 instance during the directed frame.
    int st5_cyc = -1;
    int mv5_cyc = -1;
    always @(negedge clk) begin
        if (!rst && cyc >= 1 && core_start5 && st5_cyc < 0) st5_cyc = cyc;
        if (!rst && cyc >= 1 && m_valid5 && mv5_cyc < 0) mv5_cyc = cyc;
    end

    typedef struct {
        logic       rst, sv;
        logic [7:0] re;
        logic       e_rdy, e_st, e_mv;
        logic [2:0] e_idx;
        logic       e_last;
        logic [7:0] e_re;
        logic       e_busy;
    } vec_t;
    vec_t tbl[22];

    initial begin
        logic [63:0] exp_re, exp_im;
        bit found;
        for (int i = 0; i < 22; i++) begin
            tbl[i] = '{rst: (i == 0), sv: (i >= 1 && i <= 8), re: (i >= 1 && i <= 8) ? 8'(i - 1) : 8'd0,
                       e_rdy: (i != 0 && i != 9), e_st: (i == 9), e_mv: (i >= 13 && i <= 20),
                       e_idx: (i >= 13 && i <= 20) ? 3'(i - 13) : 3'd0, e_last: (i == 20),
                       e_re: (i >= 13 && i <= 20) ? 8'(i - 13) : 8'd0, e_busy: (i >= 2 && i <= 20)};
        end
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        s_re = '0;
        s_im = '0;

        // Directed single frame from reset, no backpressure.
        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst;
            s_valid = tbl[i].sv;
            s_re = tbl[i].re;
            s_im = 8'd0 - tbl[i].re;
            m_ready = 1'b1;
            sample_and_check();
            check("tbl_s_ready", 64'(s_ready), 64'(tbl[i].e_rdy));
            if (!tbl[i].rst) begin
                check("tbl_core_start", 64'(core_start), 64'(tbl[i].e_st));
                check("tbl_m_valid", 64'(m_valid), 64'(tbl[i].e_mv));
                check("tbl_m_last", 64'(m_last), 64'(tbl[i].e_last));
                check("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
                if (tbl[i].e_mv) begin
                    check("tbl_m_index", 64'(m_index), 64'(tbl[i].e_idx));
                    check("tbl_m_re", 64'(m_re), 64'(tbl[i].e_re));
                end
            end
            advance();
        end
        for (int k = 0; k < 8; k++) begin
            exp_re[k*W +: W] = 8'(k);
            exp_im[k*W +: W] = 8'(-k);
        end
        check("launch_hold_re", core_in_re, exp_re);
        check("launch_hold_im", core_in_im, exp_im);
        run(6, 3, 0);
        check("lat5_start_to_valid", 64'(mv5_cyc - st5_cyc), 64'(P5 + 1));

        // Output backpressure, then two frames collected against a stalled sink.
        run(70, 0, 1);
        run(40, 3, 0);
        run(20, 0, 3);
        check("stall_s_ready", 64'(s_ready), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        run(60, 3, 0);

        // Sparse input valid.
        run(90, 1, 0);
        run(40, 3, 0);

        // Reset after five samples, then reset during drain of bin 3.
        run(5, 0, 0);
        reset_cycle();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            drive(0, 0);
            sample_and_check();
            if (e_mvalid && fl_idx == 3) found = 1'b1;
            else advance();
        end
        check("reach_drain_bin3", 64'(found), 64'd1);
        if (found) begin
            rst = 1'b1;
            check("drain3_index", 64'(m_index), 64'd3);
            advance();
            rst = 1'b0;
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_m_index", 64'(m_index), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
        end
        run(8, 0, 0);
        run(30, 3, 0);

        // Random traffic on both sides.
        run(500, 2, 2);
        run(60, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
